// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decoder with multi-cycle M-op sequencing
// Optional RV32M decode and busy sequencing: define ALU_CTRL_RV32M_EN.
`timescale 1ns/1ps
module alu_ctrl_seq #(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  output logic [OP_W-1:0] op_o,
  output logic            op_valid_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam logic [4:0] C_AND  = 5'd0;
  localparam logic [4:0] C_OR   = 5'd1;
  localparam logic [4:0] C_ADD  = 5'd2;
  localparam logic [4:0] C_SLL  = 5'd3;
  localparam logic [4:0] C_XOR  = 5'd4;
  localparam logic [4:0] C_SLT  = 5'd5;
  localparam logic [4:0] C_SUB  = 5'd6;
  localparam logic [4:0] C_SLTU = 5'd7;
  localparam logic [4:0] C_SRL  = 5'd8;
  localparam logic [4:0] C_SRA  = 5'd9;
  localparam logic [4:0] C_BEQ  = 5'd10;
  localparam logic [4:0] C_BNE  = 5'd11;
  localparam logic [4:0] C_BLT  = 5'd12;
  localparam logic [4:0] C_BGE  = 5'd13;
  localparam logic [4:0] C_BLTU = 5'd14;
  localparam logic [4:0] C_BGEU = 5'd15;
  localparam logic [4:0] C_ILL  = 5'd31;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;

  logic [4:0]      dec_code;
  logic            accept;
  logic [OP_W-1:0] op_q, op_d;
  logic            op_valid_q, op_valid_d;
  logic            illegal_q, illegal_d;

`ifdef ALU_CTRL_RV32M_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam int CNT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_m;

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == BUSY);
`else
  logic lat_unused;
  assign lat_unused = (MAX_LAT > 0);
  assign ready_o    = 1'b1;
  assign busy_o     = 1'b0;
`endif

  // Shared funct3 map for R-type funct7=0 and I-type ALU ops
  function automatic logic [4:0] base_code(input logic [2:0] f3);
    case (f3)
      3'b000:  base_code = C_ADD;
      3'b001:  base_code = C_SLL;
      3'b010:  base_code = C_SLT;
      3'b011:  base_code = C_SLTU;
      3'b100:  base_code = C_XOR;
      3'b101:  base_code = C_SRL;
      3'b110:  base_code = C_OR;
      default: base_code = C_AND;
    endcase
  endfunction

  // Decode alu_op/funct fields into an operation code
  always_comb begin
    dec_code = C_ILL;
`ifdef ALU_CTRL_RV32M_EN
    dec_m = 1'b0;
`endif
    case (alu_op)
      2'b00: dec_code = C_ADD;
      2'b01: begin
        case (funct3)
          3'b000:  dec_code = C_BEQ;
          3'b001:  dec_code = C_BNE;
          3'b100:  dec_code = C_BLT;
          3'b101:  dec_code = C_BGE;
          3'b110:  dec_code = C_BLTU;
          3'b111:  dec_code = C_BGEU;
          default: dec_code = C_ILL;
        endcase
      end
      2'b10: begin
        if (funct7 == F7_BASE) begin
          dec_code = base_code(funct3);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      dec_code = C_SUB;
          else if (funct3 == 3'b101) dec_code = C_SRA;
        end
`ifdef ALU_CTRL_RV32M_EN
        else if (funct7 == F7_MULDIV) begin
          dec_code = {2'b10, funct3};
          dec_m    = 1'b1;
        end
`endif
      end
      default: begin
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) dec_code = C_SLL;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec_code = C_SRL;
            else if (funct7 == F7_ALT) dec_code = C_SRA;
          end
          default: dec_code = base_code(funct3);
        endcase
      end
    endcase
  end

  assign accept = valid_i & ready_o & ~flush_i;

  // Next-state: load on accept, count down M-ops, flush wins over everything
  always_comb begin
    op_d       = op_q;
    op_valid_d = 1'b0;
    illegal_d  = 1'b0;
`ifdef ALU_CTRL_RV32M_EN
    state_d    = state_q;
    cnt_d      = cnt_q;
`endif
    if (accept) begin
      op_d       = OP_W'(dec_code);
      op_valid_d = 1'b1;
      illegal_d  = (dec_code == C_ILL);
`ifdef ALU_CTRL_RV32M_EN
      if (dec_m) begin
        op_valid_d = 1'b0;
        state_d    = BUSY;
        cnt_d      = funct3[2] ? DIV_CNT : MUL_CNT;
      end
`endif
    end
`ifdef ALU_CTRL_RV32M_EN
    if (state_q == BUSY) begin
      if (cnt_q == '0) begin
        state_d    = IDLE;
        op_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    if (flush_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      op_valid_d = 1'b0;
      illegal_d  = 1'b0;
    end
`endif
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= '0;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef ALU_CTRL_RV32M_EN
      state_q    <= IDLE;
      cnt_q      <= '0;
`endif
    end else begin
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      illegal_q  <= illegal_d;
`ifdef ALU_CTRL_RV32M_EN
      state_q    <= state_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign op_o       = op_q;
  assign op_valid_o = op_valid_q;
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed self-checking bench for alu_ctrl_seq
`timescale 1ns/1ps
module tb_alu_ctrl_seq;
  localparam int OP_W    = 5;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            valid_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [1:0]      alu_op = 2'b00;
  logic [6:0]      funct7 = 7'h00;
  logic [2:0]      funct3 = 3'b000;
  logic            ready_o;
  logic [OP_W-1:0] op_o;
  logic            op_valid_o;
  logic            illegal_o;
  logic            busy_o;

  int n_cmp = 0;
  int n_mis = 0;
  logic busy_seen = 1'b0;

  int br_exp[8] = '{10, 11, 31, 31, 12, 13, 14, 15};
  int r_exp[8]  = '{2, 3, 5, 7, 4, 8, 1, 0};

  alu_ctrl_seq #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .flush_i    (flush_i),
    .alu_op     (alu_op),
    .funct7     (funct7),
    .funct3     (funct3),
    .op_o       (op_o),
    .op_valid_o (op_valid_o),
    .illegal_o  (illegal_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy_o) busy_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3);
    valid_i = v;
    alu_op  = aop;
    funct7  = f7;
    funct3  = f3;
    flush_i = 1'b0;
  endtask

  // Present one single-cycle op and check the pulse in the following cycle
  task automatic issue(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                       input logic [2:0] f3, input int exp);
    drive(1'b1, aop, f7, f3);
    tick();
    chk({tag, ".op"}, op_o, exp);
    chk({tag, ".vld"}, op_valid_o, 1);
    chk({tag, ".ill"}, illegal_o, (exp == 31) ? 1 : 0);
    chk({tag, ".busy"}, busy_o, 0);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst.op", op_o, 0);
    chk("rst.vld", op_valid_o, 0);
    chk("rst.ill", illegal_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.rdy", ready_o, 1);
    reset_n = 1'b1;
    tick();

    issue("sub", 2'b10, 7'b0100000, 3'b000, 6);
    drive(1'b0, 2'b00, 7'h00, 3'b000);
    tick();
    chk("sub.vld_off", op_valid_o, 0);
    chk("sub.hold", op_o, 6);

    for (int i = 0; i < 8; i++) issue($sformatf("br%0d", i), 2'b01, 7'h55, 3'(i), br_exp[i]);
    for (int i = 0; i < 8; i++) issue($sformatf("r%0d", i), 2'b10, 7'h00, 3'(i), r_exp[i]);

    issue("r_sra", 2'b10, 7'b0100000, 3'b101, 9);
    issue("r_alt_bad", 2'b10, 7'b0100000, 3'b001, 31);
    issue("r_f7_bad", 2'b10, 7'b0000010, 3'b000, 31);
    issue("i_add", 2'b11, 7'h55, 3'b000, 2);
    issue("i_sll", 2'b11, 7'h00, 3'b001, 3);
    issue("i_sll_bad", 2'b11, 7'b0100000, 3'b001, 31);
    issue("i_srl", 2'b11, 7'h00, 3'b101, 8);
    issue("i_sra", 2'b11, 7'b0100000, 3'b101, 9);
    issue("i_sr_bad", 2'b11, 7'b0000010, 3'b101, 31);
    issue("i_or", 2'b11, 7'h7f, 3'b110, 1);
    issue("ls_add", 2'b00, 7'h7f, 3'b111, 2);

    drive(1'b1, 2'b01, 7'h00, 3'b000);
    flush_i = 1'b1;
    tick();
    chk("flush.vld", op_valid_o, 0);
    chk("flush.hold", op_o, 2);
    drive(1'b0, 2'b00, 7'h00, 3'b000);
    tick();
    chk("idle.vld", op_valid_o, 0);

`ifdef ALU_CTRL_RV32M_EN
    drive(1'b1, 2'b10, 7'b0000001, 3'b101);
    tick();
    chk("divu.op", op_o, 21);
    for (int i = 1; i <= DIV_LAT; i++) begin
      chk($sformatf("divu.busy%0d", i), busy_o, 1);
      chk($sformatf("divu.rdy%0d", i), ready_o, 0);
      chk($sformatf("divu.vld%0d", i), op_valid_o, 0);
      if (i == 1) drive(1'b1, 2'b00, 7'h00, 3'b000);
      if (i < DIV_LAT) tick();
    end
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'b000);
    chk("divu.done_vld", op_valid_o, 1);
    chk("divu.done_op", op_o, 21);
    chk("divu.done_rdy", ready_o, 1);
    chk("divu.done_busy", busy_o, 0);
    chk("divu.done_ill", illegal_o, 0);
    tick();
    chk("divu.after", op_valid_o, 0);

    drive(1'b1, 2'b10, 7'b0000001, 3'b000);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'b000);
    chk("mul.busy1", busy_o, 1);
    tick();
    chk("mul.busy2", busy_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("mulfl.busy", busy_o, 0);
    chk("mulfl.vld", op_valid_o, 0);
    chk("mulfl.rdy", ready_o, 1);
    for (int i = 0; i < MUL_LAT; i++) begin
      tick();
      chk($sformatf("mulfl.quiet%0d", i), op_valid_o, 0);
    end
    issue("mulfl.add", 2'b00, 7'h00, 3'b000, 2);

    drive(1'b1, 2'b10, 7'b0000001, 3'b100);
    tick();
    drive(1'b0, 2'b00, 7'h00, 3'b000);
    repeat (2) tick();
    chk("div.busy", busy_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("divrst.busy", busy_o, 0);
    chk("divrst.rdy", ready_o, 1);
    chk("divrst.op", op_o, 0);
    chk("divrst.vld", op_valid_o, 0);
    tick();
    reset_n = 1'b1;
    tick();
`else
    issue("mul_ill", 2'b10, 7'b0000001, 3'b000, 31);
    issue("divu_ill", 2'b10, 7'b0000001, 3'b101, 31);
    drive(1'b0, 2'b00, 7'h00, 3'b000);
    repeat (3) tick();
    chk("nobusy", busy_seen, 0);
    chk("rdy_tied", ready_o, 1);

    drive(1'b1, 2'b01, 7'h00, 3'b110);
    tick();
    chk("pre_rst.op", op_o, 14);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.vld", op_valid_o, 0);
    chk("midrst.op", op_o, 0);
    chk("midrst.rdy", ready_o, 1);
    drive(1'b0, 2'b00, 7'h00, 3'b000);
    tick();
    reset_n = 1'b1;
    tick();
`endif
    chk("end.vld", op_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Parametrised, registered successor to the combinational ALU control decoder. Decodes `alu_op`/`funct3`/`funct7` into a 5-bit ALU operation code covering RV32I R-type, I-type, branch compares and (optionally) RV32M. Sequences multi-cycle multiply/divide with a valid/ready handshake and busy stall. Sits between the main decoder and the execute stage.

## Interface
- `OP_W`, 5, operation code width (min 5)
- `MUL_LAT`, 4, busy cycles for MUL/MULH/MULHSU/MULHU (≥1)
- `DIV_LAT`, 32, busy cycles for DIV/DIVU/REM/REMU (≥1)
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  decode fields valid this cycle
- `ready_o`  out  1  block can accept; `= (state==IDLE)`
- `flush_i`  in  1  abort in-flight op, discard current input
- `alu_op`  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- `funct7`  in  7  instr[31:25]
- `funct3`  in  3  instr[14:12]
- `op_o`  out  OP_W  registered operation code
- `op_valid_o`  out  1  one-cycle pulse: `op_o` result ready
- `illegal_o`  out  1  pulses with `op_valid_o` for undecodable input
- `busy_o`  out  1  multi-cycle op in flight

## Operation
- Codes: AND 0, OR 1, ADD 2, SLL 3, XOR 4, SLT 5, SUB 6, SLTU 7, SRL 8, SRA 9, BEQ 10, BNE 11, BLT 12, BGE 13, BLTU 14, BGEU 15, MUL 16, MULH 17, MULHSU 18, MULHU 19, DIV 20, DIVU 21, REM 22, REMU 23, ILLEGAL 31.
- `alu_op`=00 → ADD, funct fields ignored.
- 01 → funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 ILLEGAL.
- 10, funct7=0000000 → funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- 10, funct7=0100000 → 000 SUB, 101 SRA, else ILLEGAL.
- 10, funct7=0000001 → MUL+funct3 (16..23).
- 10, any other funct7 → ILLEGAL.
- 11 → same as R-type funct7=0000000 map, funct7 ignored, except: 001 needs funct7=0000000 else ILLEGAL; 101 with funct7=0100000 → SRA, 0000000 → SRL, else ILLEGAL; no SUB.
- Accept = `valid_i & ready_o & !flush_i`.
- FSM: IDLE, BUSY.
  - IDLE + accept of M-op → BUSY, counter = LAT−1 (MUL_LAT or DIV_LAT per funct3[2]).
  - BUSY: counter decrements each cycle. At counter==0 → IDLE, `op_valid_o` pulse next cycle.
  - Any state + `flush_i` → IDLE, counter 0, no `op_valid_o`.
- `op_o` is loaded on accept and held until next accept.
- Counter width `$clog2(max(MUL_LAT,DIV_LAT))`, minimum 1 bit.

## Timing
- Reset (async assert, sync release): `op_o`=0, `op_valid_o`=0, `illegal_o`=0, `busy_o`=0, state IDLE, `ready_o`=1.
- Base/illegal op accepted at edge T → `op_valid_o`=1 for exactly cycle T+1. Back-to-back accepts give continuous pulses.
- M-op accepted at edge T:
  - `busy_o`=1 and `ready_o`=0 for cycles T+1..T+LAT.
  - `op_valid_o`=1 in cycle T+LAT+1, with `ready_o`=1 that cycle.
- `flush_i` takes effect at the same edge. It overrides both the counter-expiry pulse and a same-cycle accept.
- `valid_i` while `ready_o`=0 is ignored; no queueing.
- Reset asserted mid-BUSY → immediate return to reset values.

## Configuration
- `ALU_CTRL_RV32M_EN` defined: M decode, BUSY state and counter are present as above.
- Undefined:
  - funct7=0000001 with `alu_op`=10 decodes ILLEGAL.
  - No BUSY state or counter; `busy_o` tied 0, `ready_o` tied 1.
  - `MUL_LAT`/`DIV_LAT` unused.

## Test plan
- Reset, then `alu_op`=10, funct7=0100000, funct3=000 at edge T → `op_o`=6, `op_valid_o` high only in T+1, `illegal_o`=0.
- Sweep all 01 funct3 values → codes 10/11/ILLEGAL/ILLEGAL/12/13/14/15. 010 and 011 raise `illegal_o`.
- DIVU (funct7=0000001, funct3=101), DIV_LAT=32 → `busy_o` for 32 cycles, `op_o`=21, `op_valid_o` in cycle 33. A `valid_i` presented during busy is dropped.
- MUL accepted, `flush_i` at cycle 2 of BUSY → `busy_o` low next cycle, no `op_valid_o`, next ADD accepted normally.
- `reset_n` low mid-DIV → outputs at reset values immediately, `ready_o`=1.
- Macro undefined: MUL encoding → `op_o`=31, `illegal_o` pulse, `busy_o` never high.
